ai_move_engine: RTL
===================

Name: ai_move_engine

Overview:
- Clocked, parametrised tic-tac-toe move generator for an N x N board; it plays a configurable mark.
- Started by a one-cycle pulse. It snapshots the board and scans lines one per cycle for a win, then a block, then takes a preference cell (center, then corners), then the first blank cell.
- The chosen move is offered on a valid/ready handshake to the board controller.
- Exposes the decision category so the verification bench can check the priority order.

Parameters:
- N, 3, board side length; N >= 3; cells = N*N; lines L = 2N+2.
- AI_MARK, 2'b10, encoding of the mark the AI plays (2'b01 = X, 2'b10 = O); the opponent mark is the other of the two.
- IDX_W, $clog2(N*N), width of the move index.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- board  in  2*N*N  cell i at board[2i+1:2i]; row-major; 00 = blank, 01 = X, 10 = O, 11 = occupied (neither mark).
- start  in  1  single-cycle request to compute a move.
- busy  out  1  high from the cycle after start is accepted until the handshake completes or board_full pulses.
- move_valid  out  1  move offered.
- move_idx  out  IDX_W  cell index of the offered move.
- move_kind  out  2  0 = WIN, 1 = BLOCK, 2 = PREF, 3 = FILL.
- move_ready  in  1  consumer accepts the move.
- board_full  out  1  one-cycle pulse when no blank cell exists.

Behaviour:
- Reset: state IDLE; busy, move_valid and board_full = 0; move_idx and move_kind = 0; line and cell counters = 0. Reset applies in any state, including mid-scan and during OFFER; no move is emitted afterwards.
- IDLE: start = 1 latches board into a snapshot register and goes to SCAN_WIN with line counter 0. start is ignored in every other state. Board changes after the latch have no effect.
- Line order: rows 0..N-1, then columns 0..N-1, then main diagonal (0, N+1, ...), then anti-diagonal (N-1, 2N-2, ...).
- Line evaluation (combinational, per cycle): count own marks, count opponent marks, and record the position of the blank cell. Encoding 11 is neither own, opponent nor blank.
- SCAN_WIN: one line per cycle. A hit is own count = N-1 with exactly one blank. On a hit, latch the blank index with kind WIN and go to OFFER. After line L-1 with no hit, go to SCAN_BLOCK.
- SCAN_BLOCK: same as SCAN_WIN, but a hit is opponent count = N-1 with one blank; kind BLOCK. After line L-1 with no hit, go to PREF.
- PREF: one cycle, priority-encoded:
  - center ((N*N-1)/2, only if N is odd) if blank;
  - else corners 0, N-1, N*N-N, N*N-1, first blank;
  - kind PREF, go to OFFER. If none is blank, go to FILL with cell counter 0.
- FILL: one cell per cycle, ascending. The first blank cell gives kind FILL, go to OFFER. If cell N*N-1 is non-blank, pulse board_full for one cycle and go to IDLE; move_valid is never asserted in this case.
- OFFER: move_valid = 1; move_idx and move_kind held stable. When move_valid & move_ready, go to IDLE next cycle; move_valid and busy drop that next cycle. move_ready outside OFFER is ignored.
- Latency, with start at cycle 0:
  - a WIN hit on line k gives move_valid at cycle k+2;
  - a BLOCK hit on line k gives move_valid at cycle L+k+2;
  - PREF gives move_valid at cycle 2L+2;
  - FILL hit on cell c gives move_valid at cycle 2L+c+3;
  - board_full at cycle 2L+N*N+2.
- Within a pass, the first line in scan order wins. A WIN on any line beats any BLOCK.

Test Plan:
- N=3, AI_MARK=O, empty board, start at cycle 0, move_ready=1 -> move_valid at cycle 18, idx 4, kind PREF; busy low at cycle 19.
- O at cells 3,4 and X at cells 0,1 -> idx 5, kind WIN, move_valid at cycle 3; the block on cell 2 is not chosen.
- X at 0,4 and O at 1 -> idx 8, kind BLOCK (main diagonal, line 6), move_valid at cycle 16.
- Full board X O X / X O O / O X X, start -> board_full pulse at cycle 27 only; move_valid stays 0; busy low at cycle 28.
- Empty board with move_ready held low 5 cycles after move_valid -> idx and kind stable; accept on the 6th cycle; idle on the next cycle. start pulses during OFFER are ignored.
- rst at cycle 5 of a scan -> all outputs 0 the next cycle with no move. Then an N=4, AI_MARK=X instance on an empty board gives idx 0, kind PREF at cycle 22.

Source files
------------

// File: rtl/ai_move_engine_if.sv
// ai_move_engine_if
//   This interface carries the handshake and bus between the board controller and
//   the tic-tac-toe move engine.
//   Signals:
//     board      - 2*N*N; cell i at [2i+1:2i], row-major (00 blank, 01 X, 10 O, 11 occupied)
//     start      - one-cycle request to compute a move
//     busy       - engine is working on a request
//     move_valid - a move is being offered
//     move_idx   - cell index of the offered move
//     move_kind  - 0 WIN, 1 BLOCK, 2 PREF, 3 FILL
//     move_ready - consumer accepts the offered move
//     board_full - one-cycle pulse when no blank cell exists
//   Modports: master = board controller, slave = move engine.
interface ai_move_engine_if #(
  parameter int N     = 3,
  parameter int IDX_W = $clog2(N*N)
);
  logic [2*N*N-1:0] board;
  logic             start;
  logic             busy;
  logic             move_valid;
  logic [IDX_W-1:0] move_idx;
  logic [1:0]       move_kind;
  logic             move_ready;
  logic             board_full;

  modport master (
    output board, start, move_ready,
    input  busy, move_valid, move_idx, move_kind, board_full
  );

  modport slave (
    input  board, start, move_ready,
    output busy, move_valid, move_idx, move_kind, board_full
  );
endinterface

// File: rtl/ai_move_engine.sv
// ai_move_engine
//   This is the move generator for an N x N tic-tac-toe board. It plays the mark AI_MARK.
//   When start arrives, the engine snapshots the board. It then scans the lines one per
//   cycle, first looking for a win and then for a block. If neither is found, it tries the
//   preference cells: the center first, then the corners. As a last resort it takes the
//   first blank cell. The chosen move is offered on a valid/ready handshake.
//   Ports:
//     clk - system clock
//     rst - synchronous active-high reset
//     bus - ai_move_engine_if.slave (board, start, busy, move_valid, move_idx,
//           move_kind, move_ready, board_full)
module ai_move_engine #(
  parameter int         N       = 3,
  parameter logic [1:0] AI_MARK = 2'b10,
  parameter int         IDX_W   = $clog2(N*N)
) (
  input logic             clk,
  input logic             rst,
  ai_move_engine_if.slave bus
);
  localparam int         CELLS    = N*N;
  localparam int         L        = 2*N + 2;
  localparam int         LINE_W   = $clog2(L);
  localparam logic [1:0] OPP_MARK = (AI_MARK == 2'b01) ? 2'b10 : 2'b01;

  localparam logic [1:0] K_WIN   = 2'd0;
  localparam logic [1:0] K_BLOCK = 2'd1;
  localparam logic [1:0] K_PREF  = 2'd2;
  localparam logic [1:0] K_FILL  = 2'd3;

  typedef enum logic [2:0] {IDLE, SCAN_WIN, SCAN_BLOCK, PREF, FILL, OFFER} state_t;

  state_t             state;
  logic [2*CELLS-1:0] snap;
  logic [LINE_W-1:0]  line_cnt;
  logic [IDX_W-1:0]   cell_cnt;
  logic               busy_r;
  logic               valid_r;
  logic               full_r;
  logic [IDX_W-1:0]   idx_r;
  logic [1:0]         kind_r;

  // Cell index of position j on line l. The lines are ordered as follows: rows first,
  // then columns, then the main diagonal, then the anti-diagonal.
  function automatic int line_cell(input int l, input int j);
    if (l < N)             return l*N + j;
    else if (l < 2*N)      return j*N + (l - N);
    else if (l == 2*N)     return j*(N + 1);
    else                   return (j + 1)*(N - 1);
  endfunction

  // Returns {hit, blank_idx}. A hit means that N-1 cells hold mark mk and exactly one
  // cell is blank. Cells encoded 11 count as neither the mark nor blank.
  function automatic logic [IDX_W:0] line_hit(input logic [2*CELLS-1:0] b,
                                              input int l, input logic [1:0] mk);
    int               cnt;
    int               blanks;
    int               c;
    logic [IDX_W-1:0] pos;
    cnt    = 0;
    blanks = 0;
    pos    = '0;
    for (int j = 0; j < N; j++) begin
      c = line_cell(l, j);
      if (b[2*c +: 2] == mk) cnt++;
      else if (b[2*c +: 2] == 2'b00) begin
        blanks++;
        pos = IDX_W'(c);
      end
    end
    return {(cnt == N - 1) && (blanks == 1), pos};
  endfunction

  // Returns {found, idx}. The center is only a candidate on odd-sized boards.
  function automatic logic [IDX_W:0] pref_pick(input logic [2*CELLS-1:0] b);
    logic [IDX_W:0] r;
    r = '0;
    if ((N % 2 == 1) && (b[2*((CELLS-1)/2) +: 2] == 2'b00)) r = {1'b1, IDX_W'((CELLS-1)/2)};
    else if (b[0 +: 2] == 2'b00)                            r = {1'b1, IDX_W'(0)};
    else if (b[2*(N-1) +: 2] == 2'b00)                      r = {1'b1, IDX_W'(N-1)};
    else if (b[2*(CELLS-N) +: 2] == 2'b00)                  r = {1'b1, IDX_W'(CELLS-N)};
    else if (b[2*(CELLS-1) +: 2] == 2'b00)                  r = {1'b1, IDX_W'(CELLS-1)};
    return r;
  endfunction

  logic [IDX_W:0] win_res;
  logic [IDX_W:0] blk_res;
  logic [IDX_W:0] pref_res;
  logic           cell_blank;

  always_comb begin
    win_res    = line_hit(snap, int'(line_cnt), AI_MARK);
    blk_res    = line_hit(snap, int'(line_cnt), OPP_MARK);
    pref_res   = pref_pick(snap);
    cell_blank = (snap[2*int'(cell_cnt) +: 2] == 2'b00);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy_r   <= 1'b0;
      valid_r  <= 1'b0;
      full_r   <= 1'b0;
      idx_r    <= '0;
      kind_r   <= '0;
      line_cnt <= '0;
      cell_cnt <= '0;
    end else begin
      full_r <= 1'b0;
      case (state)
        IDLE: begin
          // busy stays high for the board_full cycle and drops here.
          busy_r <= 1'b0;
          if (bus.start) begin
            snap     <= bus.board;
            line_cnt <= '0;
            busy_r   <= 1'b1;
            state    <= SCAN_WIN;
          end
        end
        SCAN_WIN: begin
          if (win_res[IDX_W]) begin
            idx_r   <= win_res[IDX_W-1:0];
            kind_r  <= K_WIN;
            valid_r <= 1'b1;
            state   <= OFFER;
          end else if (line_cnt == LINE_W'(L - 1)) begin
            line_cnt <= '0;
            state    <= SCAN_BLOCK;
          end else begin
            line_cnt <= line_cnt + LINE_W'(1);
          end
        end
        SCAN_BLOCK: begin
          if (blk_res[IDX_W]) begin
            idx_r   <= blk_res[IDX_W-1:0];
            kind_r  <= K_BLOCK;
            valid_r <= 1'b1;
            state   <= OFFER;
          end else if (line_cnt == LINE_W'(L - 1)) begin
            line_cnt <= '0;
            state    <= PREF;
          end else begin
            line_cnt <= line_cnt + LINE_W'(1);
          end
        end
        PREF: begin
          if (pref_res[IDX_W]) begin
            idx_r   <= pref_res[IDX_W-1:0];
            kind_r  <= K_PREF;
            valid_r <= 1'b1;
            state   <= OFFER;
          end else begin
            cell_cnt <= '0;
            state    <= FILL;
          end
        end
        FILL: begin
          if (cell_blank) begin
            idx_r   <= cell_cnt;
            kind_r  <= K_FILL;
            valid_r <= 1'b1;
            state   <= OFFER;
          end else if (cell_cnt == IDX_W'(CELLS - 1)) begin
            full_r <= 1'b1;
            state  <= IDLE;
          end else begin
            cell_cnt <= cell_cnt + IDX_W'(1);
          end
        end
        OFFER: begin
          if (bus.move_ready) begin
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy       = busy_r;
  assign bus.move_valid = valid_r;
  assign bus.move_idx   = idx_r;
  assign bus.move_kind  = kind_r;
  assign bus.board_full = full_r;
endmodule
